mutual_rule_scheduler: RTL and testbench
========================================

// Module: mutual_rule_scheduler
// PURPOSE
// - Drives the rule-select input io_en_a of the generated mutual-exclusion system (3 clients, state n[i], flag x).
// - Watches the system state and picks one guard-true rule per grant, round-robin over the rules.
// - Flags starvation, deadlock and broken mutual-exclusion invariants for the equivalence and formal benches.
// PARAMETERS
// - NUM_CLIENTS    3   number of clients; rule count R = 4*NUM_CLIENTS (12)
// - SEL_W          4   width of io_en_a; must satisfy 2**SEL_W > R
// - STARVE_LIMIT  16   consecutive missed grants before a client is flagged starved
// - DEADLOCK_LIM   8   consecutive SEL cycles with no enabled rule before deadlock is flagged
// PORTS
// - clock         in   1            single clock, rising edge
// - reset         in   1            asynchronous, active-low
// - io_go         in   1            1 = scheduling allowed; 0 = hold in SEL and issue nothing
// - io_n_state    in   2*NUM_CLIENTS  client i state in bits [2i+1:2i]: I=0, T=1, C=2, E=3
// - io_x          in   1            system lock flag x
// - io_en_a       out  SEL_W        rule index to the system; NOP = all ones
// - io_valid      out  1            1 while io_en_a holds a real rule
// - io_starve     out  NUM_CLIENTS  sticky per-client starvation flag
// - io_deadlock   out  1            sticky deadlock flag
// - io_inv_err    out  1            sticky invariant-violation flag
// BEHAVIOUR
// - Rule index: idx = 4*client + r.
//   - r=0 Try: guard n==I
//   - r=1 Crit: guard n==T && x
//   - r=2 Exit: guard n==C
//   - r=3 Idle: guard n==E
// - Indices R .. 2**SEL_W-1 are never issued, apart from the NOP code (all ones).
// - Reset (async, while reset==0):
//   - FSM goes to SEL; rr pointer = 0.
//   - io_en_a = NOP; io_valid = 0; io_starve, io_deadlock, io_inv_err = 0.
//   - All counters are cleared.
// - FSM has two states, SEL and ISSUE.
//   - SEL: io_en_a = NOP. Guards are evaluated from the current inputs.
//   - SEL with io_go=1 and any guard true: register the winning idx into io_en_a, set io_valid=1, go to ISSUE.
//   - ISSUE: lasts exactly one cycle. The system commits the rule at the end of this cycle.
//   - Leaving ISSUE: io_en_a <= NOP, io_valid <= 0, return to SEL.
//   - Result: at most one grant every 2 cycles. SEL always sees the state after the previous commit.
//   - Registered output; latency from input state to io_en_a is 1 cycle.
// - Round-robin arbitration:
//   - Search starts at the pointer and wraps modulo R.
//   - On a grant, pointer <= (idx+1) mod R; idx = R-1 wraps the pointer to 0.
//   - With no grant the pointer holds.
// - Deadlock counter:
//   - Increments on each SEL cycle with io_go=1 and no guard true; saturates at DEADLOCK_LIM.
//   - Clears on any grant.
//   - io_deadlock is set when the counter reaches DEADLOCK_LIM and stays set until reset.
// - Starvation counter (per client):
//   - Increments on each grant to another client while this client has a true guard.
//   - Clears on a grant to this client; saturates at STARVE_LIMIT.
//   - io_starve[i] is set when the counter reaches STARVE_LIMIT and stays set until reset.
// - Invariant check, every cycle:
//   - Condition A: more than one client in C or E.
//   - Condition B: x==1 while any client is in C or E.
//   - If either holds, io_inv_err is set on the next edge and stays set until reset.
// - io_go=0:
//   - In SEL, no grant is made and the deadlock counter does not count.
//   - A grant already in ISSUE still completes.
// - Reset asserted mid-ISSUE: io_en_a goes to NOP immediately (asynchronous); no partial hold.
// STRUCTURE
// - mutual_pkg (shared) holds:
//   - client state encoding (I/T/C/E) and rule encoding (TRY/CRIT/EXIT/IDLE);
//   - the NOP constant;
//   - the function rule_idx(client, r).
// - Sub-module rr_arbiter:
//   - R-bit request vector plus pointer in; one-hot grant, index and any flag out.
//   - Purely combinational; instantiated once.
// - Top level holds the FSM, output registers, the pointer, the counters and the invariant checker.
// TESTING
// - Hold reset low 3 cycles -> io_en_a=4'hF, io_valid=0, all flags 0; the FSM is still in SEL after reset rises.
// - From all-I with x=1 and io_go=1 -> grants 0, 4, 8 on alternating cycles, each with io_valid=1 for one cycle and NOP between.
// - Client 0 alone, model stepping the state -> grants 0, 1, 2, 3 (Try, Crit, Exit, Idle); x follows 1 -> 0 -> 1.
// - All clients in T, x=1 -> exactly one Crit grant (1, 5 or 9, per the pointer); afterwards x=0 blocks the other Crit rules.
// - Force all T with x=0 for DEADLOCK_LIM SEL cycles -> no grant, io_deadlock=1 at the limit, and it stays 1 after the inputs recover.
// - Force n0=C, n1=E -> io_inv_err=1 on the next edge.
// - Pulse reset during ISSUE -> io_en_a=NOP at once.

Source files
------------

// File: rtl/mutual_pkg.sv
// rtl/mutual_pkg.sv - shared encodings and helpers for the mutual-exclusion rule scheduler
//
// Holds the client state encoding, the per-client rule encoding, the scheduler
// FSM state type, the NOP rule-select code and the rule index helper.
package mutual_pkg;

    // Client state n[i] as seen on io_n_state
    typedef enum logic [1:0] {
        CS_I = 2'd0,
        CS_T = 2'd1,
        CS_C = 2'd2,
        CS_E = 2'd3
    } client_state_t;

    // Rule offset within one client's block of four rules
    typedef enum logic [1:0] {
        RULE_TRY  = 2'd0,
        RULE_CRIT = 2'd1,
        RULE_EXIT = 2'd2,
        RULE_IDLE = 2'd3
    } rule_t;

    typedef enum logic {
        SCH_SEL   = 1'b0,
        SCH_ISSUE = 1'b1
    } sched_state_t;

    // Rule-select code meaning "no rule"; its width is the default select width
    localparam logic [3:0] NOP = 4'hF;

    function automatic int rule_idx(input int client, input rule_t r);
        return 4 * client + int'(r);
    endfunction

endpackage

// File: rtl/mutual_rule_scheduler_rr_arbiter.sv
// rtl/mutual_rule_scheduler_rr_arbiter.sv - combinational round-robin arbiter over the rule requests
//
// Ports:
//   req    in   R      one bit per rule, 1 = guard true
//   ptr    in   PTR_W  rule index where the search starts (0 .. R-1)
//   grant  out  R      one-hot winning rule
//   idx    out  PTR_W  index of the winning rule
//   any    out  1      at least one request present
module rr_arbiter #(
    parameter int R     = 12,
    parameter int PTR_W = 4
) (
    input  logic [R-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [R-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    // Candidate k positions after the pointer, wrapped modulo R
    function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] p, input int k);
        return PTR_W'((int'(p) + k) % R);
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < R; k++) begin
            if (!any && req[wrap(ptr, k)]) begin
                any               = 1'b1;
                grant[wrap(ptr, k)] = 1'b1;
                idx               = wrap(ptr, k);
            end
        end
    end

endmodule

// File: rtl/mutual_rule_scheduler.sv
// rtl/mutual_rule_scheduler.sv - round-robin rule scheduler and monitor for the mutual-exclusion system
//
// Ports:
//   clock        in   1              rising-edge clock
//   reset        in   1              asynchronous, active-low
//   io_go        in   1              1 = scheduling allowed
//   io_n_state   in   2*NUM_CLIENTS  client i state in bits [2i+1:2i]
//   io_x         in   1              system lock flag
//   io_en_a      out  SEL_W          selected rule index, all ones = NOP
//   io_valid     out  1              io_en_a holds a real rule
//   io_starve    out  NUM_CLIENTS    sticky per-client starvation flags
//   io_deadlock  out  1              sticky deadlock flag
//   io_inv_err   out  1              sticky mutual-exclusion invariant violation
module mutual_rule_scheduler
    import mutual_pkg::*;
#(
    parameter int NUM_CLIENTS  = 3,
    parameter int SEL_W        = $bits(NOP),
    parameter int STARVE_LIMIT = 16,
    parameter int DEADLOCK_LIM = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_go,
    input  logic [2*NUM_CLIENTS-1:0] io_n_state,
    input  logic                     io_x,
    output logic [SEL_W-1:0]         io_en_a,
    output logic                     io_valid,
    output logic [NUM_CLIENTS-1:0]   io_starve,
    output logic                     io_deadlock,
    output logic                     io_inv_err
);

    localparam int R     = 4 * NUM_CLIENTS;
    localparam int PTR_W = $clog2(R);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam int DC_W  = $clog2(DEADLOCK_LIM + 1);
    localparam logic [SEL_W-1:0] NOP_SEL = '1;

    sched_state_t           state;
    logic [PTR_W-1:0]       ptr;
    logic [DC_W-1:0]        dl_cnt;
    logic [SC_W-1:0]        starve_cnt [NUM_CLIENTS];

    logic [R-1:0]           req;
    logic [R-1:0]           arb_grant;
    logic [PTR_W-1:0]       arb_idx;
    logic                   arb_any;
    logic [NUM_CLIENTS-1:0] client_req;
    logic [NUM_CLIENTS-1:0] client_hit;
    logic [NUM_CLIENTS-1:0] in_ce;
    logic                   inv_now;

    // Rule guards, one block of four per client
    for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_guard
        client_state_t s;
        assign s = client_state_t'(io_n_state[2*c +: 2]);
        assign req[rule_idx(c, RULE_TRY)]  = (s == CS_I);
        assign req[rule_idx(c, RULE_CRIT)] = (s == CS_T) && io_x;
        assign req[rule_idx(c, RULE_EXIT)] = (s == CS_C);
        assign req[rule_idx(c, RULE_IDLE)] = (s == CS_E);
        assign client_req[c] = |req[4*c +: 4];
        assign client_hit[c] = |arb_grant[4*c +: 4];
        assign in_ce[c]      = (s == CS_C) || (s == CS_E);
    end

    // At most one client may be past the lock, and the lock must be held while one is
    assign inv_now = ($countones(in_ce) > 1) || (io_x && (|in_ce));

    rr_arbiter #(
        .R     (R),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= SCH_SEL;
            ptr         <= '0;
            dl_cnt      <= '0;
            io_en_a     <= NOP_SEL;
            io_valid    <= 1'b0;
            io_starve   <= '0;
            io_deadlock <= 1'b0;
            io_inv_err  <= 1'b0;
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                starve_cnt[c] <= '0;
            end
        end else begin
            if (inv_now) begin
                io_inv_err <= 1'b1;
            end
            case (state)
                SCH_SEL: begin
                    if (io_go) begin
                        if (arb_any) begin
                            io_en_a  <= SEL_W'(arb_idx);
                            io_valid <= 1'b1;
                            state    <= SCH_ISSUE;
                            ptr      <= (arb_idx == PTR_W'(R - 1)) ? '0 : arb_idx + 1'b1;
                            dl_cnt   <= '0;
                            // Flags rise on the same edge the counter reaches its limit
                            for (int c = 0; c < NUM_CLIENTS; c++) begin
                                if (client_hit[c]) begin
                                    starve_cnt[c] <= '0;
                                end else if (client_req[c] && starve_cnt[c] != SC_W'(STARVE_LIMIT)) begin
                                    starve_cnt[c] <= starve_cnt[c] + 1'b1;
                                    if (starve_cnt[c] == SC_W'(STARVE_LIMIT - 1)) begin
                                        io_starve[c] <= 1'b1;
                                    end
                                end
                            end
                        end else if (dl_cnt != DC_W'(DEADLOCK_LIM)) begin
                            dl_cnt <= dl_cnt + 1'b1;
                            if (dl_cnt == DC_W'(DEADLOCK_LIM - 1)) begin
                                io_deadlock <= 1'b1;
                            end
                        end
                    end
                end
                SCH_ISSUE: begin
                    // The system commits the rule at this edge; drop back to NOP
                    io_en_a  <= NOP_SEL;
                    io_valid <= 1'b0;
                    state    <= SCH_SEL;
                end
                default: state <= SCH_SEL;
            endcase
        end
    end

endmodule

// File: tb/tb_mutual_rule_scheduler.sv
// tb/tb_mutual_rule_scheduler.sv - self-checking bench for mutual_rule_scheduler
module tb_mutual_rule_scheduler;
    import mutual_pkg::*;

    localparam int NC = 3;
    localparam int R  = 12;
    localparam int SL = 16;
    localparam int DL = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_go;
    logic [5:0] io_n_state;
    logic       io_x;
    logic [3:0] io_en_a;
    logic       io_valid;
    logic [2:0] io_starve;
    logic       io_deadlock;
    logic       io_inv_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Bench-side system and stimulus
    int cs [NC];
    bit xf;
    bit go;
    bit sys_on;
    int seen [$];

    // Reference model
    bit m_issue;
    int m_en;
    bit m_valid;
    int m_ptr;
    int m_dl;
    int m_sc [NC];
    bit m_starve [NC];
    bit m_dead;
    bit m_inv;

    mutual_rule_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .io_go       (io_go),
        .io_n_state  (io_n_state),
        .io_x        (io_x),
        .io_en_a     (io_en_a),
        .io_valid    (io_valid),
        .io_starve   (io_starve),
        .io_deadlock (io_deadlock),
        .io_inv_err  (io_inv_err)
    );

    always #5 clock = ~clock;

    function automatic bit guard(input int j);
        int c;
        c = j / 4;
        case (j % 4)
            0:       return cs[c] == 0;
            1:       return cs[c] == 1 && xf;
            2:       return cs[c] == 2;
            default: return cs[c] == 3;
        endcase
    endfunction

    function automatic logic [9:0] exp_vec();
        return {4'(m_en), m_valid, m_starve[2], m_starve[1], m_starve[0], m_dead, m_inv};
    endfunction

    task automatic model_reset();
        m_issue = 0; m_en = int'(NOP); m_valid = 0; m_ptr = 0; m_dl = 0;
        m_dead = 0; m_inv = 0;
        for (int c = 0; c < NC; c++) begin
            m_sc[c] = 0; m_starve[c] = 0;
        end
    endtask

    task automatic model_step();
        int n_ce;
        int g;
        n_ce = 0;
        g = -1;
        for (int c = 0; c < NC; c++) if (cs[c] >= 2) n_ce++;
        if (n_ce > 1 || (xf && n_ce > 0)) m_inv = 1;
        if (m_issue) begin
            m_issue = 0; m_en = int'(NOP); m_valid = 0;
        end else if (go) begin
            for (int k = 0; k < R; k++)
                if (g < 0 && guard((m_ptr + k) % R)) g = (m_ptr + k) % R;
            if (g >= 0) begin
                m_issue = 1; m_en = g; m_valid = 1; m_ptr = (g + 1) % R; m_dl = 0;
                for (int c = 0; c < NC; c++) begin
                    if (c == g / 4) m_sc[c] = 0;
                    else if (guard(4*c) || guard(4*c+1) || guard(4*c+2) || guard(4*c+3)) begin
                        if (m_sc[c] < SL) m_sc[c]++;
                        if (m_sc[c] == SL) m_starve[c] = 1;
                    end
                end
            end else begin
                if (m_dl < DL) m_dl++;
                if (m_dl == DL) m_dead = 1;
            end
        end
    endtask

    // System commit of a granted rule
    task automatic apply_rule(input int j);
        int c;
        c = j / 4;
        case (j % 4)
            0: cs[c] = 1;
            1: begin cs[c] = 2; xf = 0; end
            2: cs[c] = 3;
            default: begin cs[c] = 0; xf = 1; end
        endcase
    endtask

    task automatic step();
        bit was_issue;
        int rule;
        was_issue = m_issue;
        rule = m_en;
        io_n_state = {2'(cs[2]), 2'(cs[1]), 2'(cs[0])};
        io_x = xf;
        io_go = go;
        @(posedge clock);
        model_step();
        #1;
        if (io_valid) seen.push_back(int'(io_en_a));
        if (sys_on && was_issue) apply_rule(rule);
    endtask

    task automatic do_reset();
        reset = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1;
        seen.delete();
    endtask

    task automatic test_reset();
        go = 1; xf = 1; sys_on = 0;
        for (int c = 0; c < NC; c++) cs[c] = 0;
        io_go = 1; io_x = 1; io_n_state = '0;
        reset = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            n_assert++;
            if ({io_en_a, io_valid, io_starve, io_deadlock, io_inv_err} !== 10'b1111_0_000_0_0) begin
                n_fail++;
                $display("FAIL reset_state cycle %0d: got %h want %h", i,
                         {io_en_a, io_valid, io_starve, io_deadlock, io_inv_err}, 10'b1111_0_000_0_0);
            end
        end
        reset = 1;
        seen.delete();
    endtask

    task automatic test_round_robin();
        int exp_g [3] = '{0, 4, 8};
        do_reset();
        sys_on = 0; go = 1; xf = 1;
        for (int c = 0; c < NC; c++) cs[c] = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_assert++;
            if ({io_en_a, io_valid, io_starve, io_deadlock, io_inv_err} !== exp_vec() || io_valid !== (i % 2 == 0)) begin
                n_fail++;
                $display("FAIL round_robin cycle %0d: got %h want %h", i,
                         {io_en_a, io_valid, io_starve, io_deadlock, io_inv_err}, exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (seen.size() != 3 || seen[i] != exp_g[i]) begin
                n_fail++;
                $display("FAIL round_robin_grant %0d: got %0d grants, want idx %0d", i, seen.size(), exp_g[i]);
            end
        end
    endtask

    task automatic test_client0();
        int exp_g [4] = '{0, 1, 2, 3};
        do_reset();
        sys_on = 1; go = 1; xf = 1;
        cs[0] = 0; cs[1] = 1; cs[2] = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_assert++;
            if ({io_en_a, io_valid, io_starve, io_deadlock, io_inv_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL client0_seq cycle %0d: got %h want %h", i,
                         {io_en_a, io_valid, io_starve, io_deadlock, io_inv_err}, exp_vec());
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_assert++;
            if (seen.size() < 4 || seen[i] != exp_g[i]) begin
                n_fail++;
                $display("FAIL client0_grant %0d: got %0d grants, want idx %0d", i, seen.size(), exp_g[i]);
            end
        end
    endtask

    task automatic test_all_t();
        int exp_g [8] = '{1, 2, 3, 5, 6, 7, 9, 10};
        do_reset();
        sys_on = 1; go = 1; xf = 1;
        for (int c = 0; c < NC; c++) cs[c] = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            n_assert++;
            if ({io_en_a, io_valid, io_starve, io_deadlock, io_inv_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL all_t cycle %0d: got %h want %h", i,
                         {io_en_a, io_valid, io_starve, io_deadlock, io_inv_err}, exp_vec());
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_assert++;
            if (seen.size() != 8 || seen[i] != exp_g[i]) begin
                n_fail++;
                $display("FAIL all_t_grant %0d: got %0d grants, want idx %0d", i, seen.size(), exp_g[i]);
            end
        end
    endtask

    task automatic test_deadlock();
        do_reset();
        sys_on = 0; xf = 0;
        for (int c = 0; c < NC; c++) cs[c] = 1;
        go = 0;
        repeat (3) step();
        go = 1;
        for (int i = 1; i <= DL + 2; i++) begin
            step();
            n_assert++;
            if ({io_en_a, io_valid, io_starve, io_deadlock, io_inv_err} !== exp_vec()
                || io_deadlock !== (i >= DL)) begin
                n_fail++;
                $display("FAIL deadlock sel_cycle %0d: got %h want %h", i,
                         {io_en_a, io_valid, io_starve, io_deadlock, io_inv_err}, exp_vec());
            end
        end
        for (int c = 0; c < NC; c++) cs[c] = 0;
        xf = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_assert++;
            if ({io_en_a, io_valid, io_starve, io_deadlock, io_inv_err} !== exp_vec() || io_deadlock !== 1'b1) begin
                n_fail++;
                $display("FAIL deadlock_sticky cycle %0d: got %h want %h", i,
                         {io_en_a, io_valid, io_starve, io_deadlock, io_inv_err}, exp_vec());
            end
        end
    endtask

    task automatic test_invariant();
        int st [3][3] = '{'{2, 0, 0}, '{2, 3, 0}, '{3, 0, 0}};
        bit sx [3] = '{0, 0, 1};
        bit want [3] = '{0, 1, 1};
        for (int t = 0; t < 3; t++) begin
            do_reset();
            sys_on = 0; go = 0; xf = sx[t];
            for (int c = 0; c < NC; c++) cs[c] = st[t][c];
            step();
            n_assert++;
            if ({io_en_a, io_valid, io_starve, io_deadlock, io_inv_err} !== exp_vec() || io_inv_err !== want[t]) begin
                n_fail++;
                $display("FAIL invariant case %0d: got inv_err %b want %b", t, io_inv_err, want[t]);
            end
        end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        sys_on = 0; go = 1; xf = 1;
        for (int c = 0; c < NC; c++) cs[c] = 0;
        step();
        step();
        step();
        n_assert++;
        if (io_valid !== 1'b1 || io_en_a !== 4'd4) begin
            n_fail++;
            $display("FAIL mid_issue_setup: got en %h valid %b want en 4 valid 1", io_en_a, io_valid);
        end
        reset = 0;
        model_reset();
        #1;
        n_assert++;
        if (io_en_a !== 4'hF || io_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_issue_reset: got en %h valid %b want en f valid 0", io_en_a, io_valid);
        end
        @(posedge clock);
        #1;
        reset = 1;
        seen.delete();
        step();
        n_assert++;
        if (io_en_a !== 4'd0 || io_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_issue_restart: got en %h valid %b want en 0 valid 1", io_en_a, io_valid);
        end
    endtask

    task automatic test_random_system();
        do_reset();
        sys_on = 1; xf = 1;
        for (int c = 0; c < NC; c++) cs[c] = $urandom_range(0, 1) == 0 ? 0 : 1;
        for (int i = 0; i < 300; i++) begin
            go = ($urandom_range(0, 3) != 0);
            step();
            n_assert++;
            if ({io_en_a, io_valid, io_starve, io_deadlock, io_inv_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_system cycle %0d: got %h want %h", i,
                         {io_en_a, io_valid, io_starve, io_deadlock, io_inv_err}, exp_vec());
            end
        end
    endtask

    task automatic test_random_forced();
        for (int blk = 0; blk < 5; blk++) begin
            do_reset();
            sys_on = 0;
            for (int i = 0; i < 80; i++) begin
                go = ($urandom_range(0, 4) != 0);
                xf = $urandom_range(0, 1);
                for (int c = 0; c < NC; c++) cs[c] = $urandom_range(0, 3);
                step();
                n_assert++;
                if ({io_en_a, io_valid, io_starve, io_deadlock, io_inv_err} !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random_forced blk %0d cycle %0d: got %h want %h", blk, i,
                             {io_en_a, io_valid, io_starve, io_deadlock, io_inv_err}, exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_client0();
        test_all_t();
        test_deadlock();
        test_invariant();
        test_reset_mid_issue();
        test_random_system();
        test_random_forced();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
